// File: rtl/vending_pkg.sv
// Shared types and helpers for the vending controller: state encoding, BCD digit type,
// and the flattened price-table lookup.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        VEND,
        CHANGE
    } vend_state_e;

    typedef logic [3:0] bcd_digit_t;

    // Price tables are zero-extended to this many 8-bit slots before lookup.
    localparam int MAX_PRODUCTS = 32;

    function automatic logic [7:0] price_lookup(input logic [MAX_PRODUCTS*8-1:0] tab,
                                                input logic [4:0]                idx);
        return tab[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/vend_bin2bcd.sv
// Combinational 0..99 binary to two-digit {tens,ones} BCD converter.
module vend_bin2bcd
    import vending_pkg::*;
#(
    parameter int W = 7
) (
    input  logic [W-1:0] bin,
    output bcd_digit_t   tens,
    output bcd_digit_t   ones
);

    localparam logic [W-1:0] TEN = W'(10);

    logic [W-1:0] q;
    logic [W-1:0] r;

    always_comb begin
        q    = bin / TEN;
        r    = bin % TEN;
        tens = bcd_digit_t'(q);
        ones = bcd_digit_t'(r);
    end

endmodule

// File: rtl/vending_controller.sv
// Vending-machine controller: coin credit, price/stock check, dispense, change handshake.
// Optional inactivity refund is compiled in when VEND_TIMEOUT_EN is defined.
module vending_controller
    import vending_pkg::*;
#(
    parameter int                      N_PRODUCTS  = 4,
    parameter int                      CREDIT_W    = 7,
    parameter int                      MAX_CREDIT  = 99,
    parameter logic [N_PRODUCTS*8-1:0] PRICES      = {8'd10, 8'd5, 8'd3, 8'd1},
    parameter int                      STOCK_W     = 4,
    parameter int                      INIT_STOCK  = 15,
    parameter int                      TIMEOUT_CYC = 1000,
    localparam int                     SEL_W       = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  coin_valid,
    input  logic [CREDIT_W-1:0]   coin_val,
    output logic                  coin_reject,
    input  logic                  vend_req,
    input  logic [SEL_W-1:0]      vend_sel,
    input  logic                  cancel,
    input  logic                  restock_valid,
    input  logic [SEL_W-1:0]      restock_id,
    output logic                  vend_valid,
    output logic [SEL_W-1:0]      vend_id,
    output logic                  err_insuff,
    output logic                  err_soldout,
    output logic                  change_valid,
    input  logic                  change_ready,
    output logic [CREDIT_W-1:0]   change_amt,
    output logic [CREDIT_W-1:0]   credit,
    output logic [7:0]            credit_bcd,
    output logic [N_PRODUCTS-1:0] sold_out,
    output logic                  timeout
);

    localparam logic [MAX_PRODUCTS*8-1:0] PRICE_TAB = (MAX_PRODUCTS*8)'(PRICES);

    vend_state_e                         state_q, state_d;
    logic [CREDIT_W-1:0]                 credit_q, credit_d;
    logic [SEL_W-1:0]                    sel_q, sel_d;
    logic [N_PRODUCTS-1:0][STOCK_W-1:0]  stock_q, stock_d;
    logic                                coin_reject_q, coin_reject_d;
    logic                                vend_valid_q, vend_valid_d;
    logic [SEL_W-1:0]                    vend_id_q, vend_id_d;
    logic                                err_insuff_q, err_insuff_d;
    logic                                err_soldout_q, err_soldout_d;
    logic                                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0]                 change_amt_q, change_amt_d;
    logic                                timeout_q, timeout_d;

    logic                                coin_live;
    logic [CREDIT_W:0]                   credit_sum;
    logic                                coin_fits;
    logic                                sel_ok;
    logic [STOCK_W-1:0]                  sel_stock;
    logic [CREDIT_W-1:0]                 price_req;
    logic [CREDIT_W-1:0]                 price_vend;
    logic [CREDIT_W-1:0]                 remainder;
    logic                                timeout_fire;

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            activity;

    always_comb begin
        activity     = coin_valid || vend_req || cancel;
        timeout_fire = (state_q == CREDIT) && !activity && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
        to_cnt_d     = '0;
        if (state_q == CREDIT && !activity && !timeout_fire)
            to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout_fire = 1'b0;
`endif

    always_comb begin
        coin_live  = coin_valid && (coin_val != '0);
        credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
        coin_fits  = credit_sum <= (CREDIT_W+1)'(MAX_CREDIT);
        sel_ok     = int'(vend_sel) < N_PRODUCTS;
        sel_stock  = '0;
        for (int i = 0; i < N_PRODUCTS; i++)
            if (SEL_W'(i) == vend_sel) sel_stock = stock_q[i];
        price_req  = CREDIT_W'(price_lookup(PRICE_TAB, 5'(vend_sel)));
        price_vend = CREDIT_W'(price_lookup(PRICE_TAB, 5'(sel_q)));
        remainder  = credit_q - price_vend;
    end

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        sel_d          = sel_q;
        stock_d        = stock_q;
        coin_reject_d  = 1'b0;
        vend_valid_d   = 1'b0;
        vend_id_d      = vend_id_q;
        err_insuff_d   = 1'b0;
        err_soldout_d  = 1'b0;
        change_valid_d = change_valid_q;
        change_amt_d   = change_amt_q;
        timeout_d      = 1'b0;

        unique case (state_q)
            IDLE, CREDIT: begin
                if (cancel) begin
                    coin_reject_d = coin_live;
                    if (state_q == CREDIT) begin
                        state_d        = CHANGE;
                        change_valid_d = 1'b1;
                        change_amt_d   = credit_q;
                    end
                end else if (timeout_fire) begin
                    timeout_d      = 1'b1;
                    state_d        = CHANGE;
                    change_valid_d = 1'b1;
                    change_amt_d   = credit_q;
                end else if (coin_live) begin
                    // A same-cycle vend_req is dropped silently behind the coin.
                    if (coin_fits) begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                        state_d  = CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (vend_req) begin
                    if (state_q == IDLE)                   err_insuff_d  = 1'b1;
                    else if (!sel_ok || sel_stock == '0)   err_soldout_d = 1'b1;
                    else if (credit_q < price_req)         err_insuff_d  = 1'b1;
                    else begin
                        state_d      = VEND;
                        sel_d        = vend_sel;
                        vend_valid_d = 1'b1;
                        vend_id_d    = vend_sel;
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_live;
                credit_d      = remainder;
                for (int i = 0; i < N_PRODUCTS; i++)
                    if (SEL_W'(i) == sel_q && stock_q[i] != '0)
                        stock_d[i] = stock_q[i] - 1'b1;
                if (remainder != '0) begin
                    state_d        = CHANGE;
                    change_valid_d = 1'b1;
                    change_amt_d   = remainder;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_live;
                if (change_valid_q && change_ready) begin
                    credit_d       = '0;
                    change_valid_d = 1'b0;
                    change_amt_d   = '0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Restock overrides any same-cycle dispense decrement.
        for (int i = 0; i < N_PRODUCTS; i++)
            if (restock_valid && SEL_W'(i) == restock_id)
                stock_d[i] = STOCK_W'(INIT_STOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            sel_q          <= '0;
            stock_q        <= {N_PRODUCTS{STOCK_W'(INIT_STOCK)}};
            coin_reject_q  <= 1'b0;
            vend_valid_q   <= 1'b0;
            vend_id_q      <= '0;
            err_insuff_q   <= 1'b0;
            err_soldout_q  <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            sel_q          <= sel_d;
            stock_q        <= stock_d;
            coin_reject_q  <= coin_reject_d;
            vend_valid_q   <= vend_valid_d;
            vend_id_q      <= vend_id_d;
            err_insuff_q   <= err_insuff_d;
            err_soldout_q  <= err_soldout_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            timeout_q      <= timeout_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_PRODUCTS; i++)
            sold_out[i] = (stock_q[i] == '0);
    end

    vend_bin2bcd #(.W(CREDIT_W)) u_bcd (
        .bin  (credit_q),
        .tens (credit_bcd[7:4]),
        .ones (credit_bcd[3:0])
    );

    assign coin_reject  = coin_reject_q;
    assign vend_valid   = vend_valid_q;
    assign vend_id      = vend_id_q;
    assign err_insuff   = err_insuff_q;
    assign err_soldout  = err_soldout_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign credit       = credit_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller; prices are product0=1, 1=3, 2=5, 3=10.
module tb_vending_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [6:0] coin_val = '0;
    logic       coin_reject;
    logic       vend_req = 1'b0;
    logic [1:0] vend_sel = '0;
    logic       cancel = 1'b0;
    logic       restock_valid = 1'b0;
    logic [1:0] restock_id = '0;
    logic       vend_valid;
    logic [1:0] vend_id;
    logic       err_insuff;
    logic       err_soldout;
    logic       change_valid;
    logic       change_ready = 1'b0;
    logic [6:0] change_amt;
    logic [6:0] credit;
    logic [7:0] credit_bcd;
    logic [3:0] sold_out;
    logic       timeout;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vending_controller #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_val(coin_val), .coin_reject(coin_reject),
        .vend_req(vend_req), .vend_sel(vend_sel), .cancel(cancel),
        .restock_valid(restock_valid), .restock_id(restock_id),
        .vend_valid(vend_valid), .vend_id(vend_id),
        .err_insuff(err_insuff), .err_soldout(err_soldout),
        .change_valid(change_valid), .change_ready(change_ready), .change_amt(change_amt),
        .credit(credit), .credit_bcd(credit_bcd), .sold_out(sold_out), .timeout(timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        coin_valid    = 1'b0;
        vend_req      = 1'b0;
        cancel        = 1'b0;
        restock_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic coin(input int v);
        coin_valid = 1'b1;
        coin_val   = 7'(v);
        tick();
    endtask

    task automatic vend(input int s);
        vend_req = 1'b1;
        vend_sel = 2'(s);
        tick();
    endtask

    initial begin
        int waited;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_credit", credit, 0);
        chk("rst_bcd", credit_bcd, 0);
        chk("rst_change_valid", change_valid, 0);
        chk("rst_change_amt", change_amt, 0);
        chk("rst_vend_valid", vend_valid, 0);
        chk("rst_sold_out", sold_out, 0);
        chk("rst_timeout", timeout, 0);

        // exact payment: coin 5 for product 2 (price 5)
        coin(5);
        chk("t1_credit", credit, 5);
        vend(2);
        chk("t1_vend_valid", vend_valid, 1);
        chk("t1_vend_id", vend_id, 2);
        tick();
        chk("t1_vend_pulse_end", vend_valid, 0);
        chk("t1_credit_zero", credit, 0);
        chk("t1_no_change", change_valid, 0);
        vend(0);
        chk("t1_idle_insuff", err_insuff, 1);

        // overpayment with held change handshake
        coin(10);
        coin(3);
        chk("t2_credit", credit, 13);
        chk("t2_bcd", credit_bcd, 8'h13);
        vend(3);
        chk("t2_vend_valid", vend_valid, 1);
        chk("t2_vend_id", vend_id, 3);
        tick();
        chk("t2_change_valid", change_valid, 1);
        chk("t2_change_amt", change_amt, 3);
        coin(1);
        chk("t2_coin_in_change", coin_reject, 1);
        chk("t2_credit_held", credit, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_valid", change_valid, 1);
            chk("t2_hold_amt", change_amt, 3);
        end
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        chk("t2_accept_valid", change_valid, 0);
        chk("t2_accept_credit", credit, 0);

        // saturation boundary
        for (int i = 0; i < 9; i++) coin(10);
        coin(5);
        chk("t3_credit95", credit, 95);
        chk("t3_bcd95", credit_bcd, 8'h95);
        coin(10);
        chk("t3_reject", coin_reject, 1);
        chk("t3_credit_kept", credit, 95);
        coin(4);
        chk("t3_credit99", credit, 99);
        chk("t3_bcd99", credit_bcd, 8'h99);
        coin(1);
        chk("t3_reject99", coin_reject, 1);
        cancel = 1'b1;
        tick();
        chk("t3_refund_amt", change_amt, 99);
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        chk("t3_refund_credit", credit, 0);

        // drain product 0
        for (int i = 0; i < 15; i++) begin
            coin(1);
            vend(0);
            chk("t4_vend_valid", vend_valid, 1);
            tick();
        end
        chk("t4_sold_out", sold_out, 4'b0001);
        coin(1);
        vend(0);
        chk("t4_soldout_err", err_soldout, 1);
        chk("t4_no_insuff", err_insuff, 0);
        chk("t4_credit_kept", credit, 1);
        restock_valid = 1'b1;
        restock_id    = 2'd0;
        tick();
        chk("t4_restocked", sold_out, 4'b0000);
        vend(0);
        chk("t4_vend_after_restock", vend_valid, 1);
        tick();
        chk("t4_credit_zero", credit, 0);

        // insufficient credit, then cancel beats coin
        coin(2);
        vend(2);
        chk("t5_insuff", err_insuff, 1);
        chk("t5_credit_kept", credit, 2);
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_val   = 7'd5;
        tick();
        chk("t5_coin_reject", coin_reject, 1);
        chk("t5_change_valid", change_valid, 1);
        chk("t5_change_amt", change_amt, 2);

        // reset while change is pending
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_change_valid", change_valid, 0);
        chk("t6_rst_change_amt", change_amt, 0);
        chk("t6_rst_credit", credit, 0);

`ifdef VEND_TIMEOUT_EN
        coin(3);
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            waited++;
            if (timeout) break;
        end
        chk("t7_timeout_pulse", timeout, 1);
        chk("t7_timeout_cycles", waited, 8);
        chk("t7_change_amt", change_amt, 3);
        tick();
        chk("t7_pulse_end", timeout, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_rst_change_valid", change_valid, 0);
        chk("t7_rst_credit", credit, 0);
        chk("t7_rst_timeout", timeout, 0);
`else
        coin(3);
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (timeout) waited++;
        end
        chk("t7_no_timeout", waited, 0);
        chk("t7_credit_held", credit, 3);
        chk("t7_no_change", change_valid, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
